// File: rtl/cnm_sw_driver.sv
// cnm_sw_driver
// Host-side driver for the complex-multiplier switch/LED operand protocol.
// It takes one set of four signed operands through a valid/ready handshake.
// Each operand is played out on the controller switches as a data word with a
// strobe pulse. The real and imaginary result bytes are then read back from
// the controller LED bus.
//
// Ports:
//   clk         system clock, rising edge
//   nreset      asynchronous active-low reset
//   in_valid    operand set offered
//   in_ready    driver idle, operand set accepted when in_valid is also high
//   rea/ima/req/imq  operands, captured on in_valid & in_ready
//   sw_out      [7:0] data word, [8] strobe, to controller switch bits 8:0
//   led_in      controller LED bus
//   re_out      real result byte (product bits 14:7)
//   im_out      imaginary result byte (product bits 14:7)
//   out_valid   one-cycle pulse, results valid
//   echo_err    sticky flag, an operand echo on led_in mismatched
//
// HOLD is the length in cycles of every phase. The controller needs two
// cycles after a strobe edge to update the LEDs, plus one cycle to sample
// them, so HOLD must be at least 3 (legal range 3..255).
module cnm_sw_driver #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] rea,
  input  logic [7:0] ima,
  input  logic [7:0] req,
  input  logic [7:0] imq,
  output logic [8:0] sw_out,
  input  logic [7:0] led_in,
  output logic [7:0] re_out,
  output logic [7:0] im_out,
  output logic       out_valid,
  output logic       echo_err
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ASSERT,
    RELEASE,
    RES_RE,
    RES_IM,
    FINISH
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] k, k_n;
  logic [7:0] op [4];
  logic [8:0] sw_n;
  logic [7:0] data_n;
  logic       phase_end;
  logic       accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == FINISH) && phase_end;

  // Next-state logic. Every phase except IDLE lasts HOLD cycles: the counter
  // is loaded with HOLD-1 on entry, and the phase ends on the cycle it reads 0.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    k_n       = k;
    phase_end = (cnt == 8'd0);
    accept    = (state == IDLE) && in_valid;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = SETUP;
          cnt_n   = HOLD_LAST;
          k_n     = 2'd0;
        end
      end
      default: begin
        if (!phase_end) begin
          cnt_n = cnt - 8'd1;
        end else begin
          cnt_n = HOLD_LAST;
          case (state)
            SETUP:   state_n = ASSERT;
            ASSERT:  state_n = RELEASE;
            RELEASE: begin
              if (k == 2'd3) begin
                state_n = RES_RE;
              end else begin
                k_n     = k + 2'd1;
                state_n = SETUP;
              end
            end
            RES_RE:  state_n = RES_IM;
            RES_IM:  state_n = FINISH;
            default: begin
              state_n = IDLE;
              cnt_n   = 8'd0;
            end
          endcase
        end
      end
    endcase

    // The switch word is derived from the next state and then registered. As
    // a result it can only change where the state changes, which is on a
    // phase boundary. On accept the operands are not stored yet, so the first
    // word comes straight from the input.
    data_n = accept ? rea : op[k_n];
    case (state_n)
      SETUP, RELEASE: sw_n = {1'b0, data_n};
      ASSERT:         sw_n = {1'b1, data_n};
      RES_IM:         sw_n = 9'h100;
      default:        sw_n = 9'h000;
    endcase
  end

  // State, phase counter, operand index and the registered switch word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      k      <= 2'd0;
      sw_out <= 9'h000;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      k      <= k_n;
      sw_out <= sw_n;
    end
  end

  // Operand capture, echo checking and result capture. The LED bus is
  // sampled only on the last cycle of a phase, which gives the controller
  // time to settle. An echo mismatch is flagged but does not stop the
  // sequence.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) begin
        op[i] <= 8'd0;
      end
      echo_err <= 1'b0;
      re_out   <= 8'd0;
      im_out   <= 8'd0;
    end else begin
      if (accept) begin
        op[0]    <= rea;
        op[1]    <= ima;
        op[2]    <= req;
        op[3]    <= imq;
        echo_err <= 1'b0;
      end
      if ((state == ASSERT) && phase_end && (led_in != op[k])) begin
        echo_err <= 1'b1;
      end
      if ((state == RES_RE) && phase_end) begin
        re_out <= led_in;
      end
      if ((state == RES_IM) && phase_end) begin
        im_out <= led_in;
      end
    end
  end

endmodule

// File: tb/tb_cnm_sw_driver.sv
// Testbench for cnm_sw_driver.
// Two drivers share the operand bus: index 0 uses HOLD=4 and index 1 uses
// HOLD=3. Each driver has its own behavioural model of the multiplier
// controller. The model echoes operands on the LEDs two cycles after each
// strobe rise. After the fourth strobe it shows the real result byte, and on
// the fifth strobe it shows the imaginary result byte.
module tb_cnm_sw_driver;

  logic clk = 1'b0;
  logic nreset;
  logic [1:0] inValid;
  logic [7:0] rea, ima, req, imq;
  wire  [1:0] inReady, outValid, echoErr;
  wire  [1:0][8:0] swOut;
  wire  [1:0][7:0] reOut, imOut;
  logic [1:0][7:0] ledIn;
  logic faultOn;

  int checkCount = 0;
  int passCount = 0;

  always #5 clk = ~clk;

  cnm_sw_driver #(.HOLD(4)) u_dut4 (
    .clk(clk), .nreset(nreset), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .rea(rea), .ima(ima), .req(req), .imq(imq), .sw_out(swOut[0]),
    .led_in(ledIn[0]), .re_out(reOut[0]), .im_out(imOut[0]),
    .out_valid(outValid[0]), .echo_err(echoErr[0])
  );

  cnm_sw_driver #(.HOLD(3)) u_dut3 (
    .clk(clk), .nreset(nreset), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .rea(rea), .ima(ima), .req(req), .imq(imq), .sw_out(swOut[1]),
    .led_in(ledIn[1]), .re_out(reOut[1]), .im_out(imOut[1]),
    .out_valid(outValid[1]), .echo_err(echoErr[1])
  );

  // Result byte: bits 14:7 of the signed complex product.
  function automatic logic [7:0] resByte(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] e,
                                         input bit imag);
    int p;
    if (imag) p = $signed(a) * $signed(e) + $signed(b) * $signed(c);
    else      p = $signed(a) * $signed(c) - $signed(b) * $signed(e);
    return p[14:7];
  endfunction

  // Controller model. A strobe rise is seen one edge after it happens, and
  // the LEDs follow one edge after that.
  logic [1:0]           prevStb;
  logic [1:0][2:0]      edges;
  logic [1:0][7:0]      stage;
  logic [1:0][3:0][7:0] mop;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prevStb <= '0;
      edges   <= '0;
      stage   <= '0;
      ledIn   <= '0;
      mop     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        prevStb[i] <= swOut[i][8];
        ledIn[i]   <= stage[i];
        if (swOut[i][8] && !prevStb[i]) begin
          if (edges[i] < 3'd4) begin
            mop[i][edges[i][1:0]] <= swOut[i][7:0];
            stage[i] <= (faultOn && i == 0 && edges[i] == 3'd1) ? 8'h00 : swOut[i][7:0];
            edges[i] <= edges[i] + 3'd1;
          end else begin
            stage[i] <= resByte(mop[i][0], mop[i][1], mop[i][2], mop[i][3], 1'b1);
            edges[i] <= 3'd5;
          end
        end else if (!swOut[i][8] && prevStb[i]) begin
          if (edges[i] == 3'd4) begin
            stage[i] <= resByte(mop[i][0], mop[i][1], mop[i][2], mop[i][3], 1'b0);
          end else if (edges[i] == 3'd5) begin
            edges[i] <= 3'd0;
            stage[i] <= 8'h00;
          end
        end
      end
    end
  end

  // Sequence monitor: counts strobe rises per transaction and flags any data
  // change made while the strobe is high or within one cycle of a strobe edge.
  logic [1:0][3:0] stbHist;
  logic [1:0][7:0] dataHist1, dataHist2, violations;
  logic [1:0][2:0] histLen, edgeCnt, lastEdges;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stbHist    <= '0;
      dataHist1  <= '0;
      dataHist2  <= '0;
      histLen    <= '0;
      edgeCnt    <= '0;
      lastEdges  <= '0;
      violations <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        stbHist[i]   <= {stbHist[i][2:0], swOut[i][8]};
        dataHist1[i] <= swOut[i][7:0];
        dataHist2[i] <= dataHist1[i];
        if (histLen[i] < 3'd4) histLen[i] <= histLen[i] + 3'd1;
        if (histLen[i] == 3'd4 && dataHist1[i] != dataHist2[i] &&
            (swOut[i][8] || (|stbHist[i][2:0])))
          violations[i] <= violations[i] + 8'd1;
        if (inValid[i] && inReady[i])
          edgeCnt[i] <= 3'd0;
        else if (swOut[i][8] && !stbHist[i][0] && histLen[i] != 3'd0)
          edgeCnt[i] <= edgeCnt[i] + 3'd1;
        if (outValid[i]) lastEdges[i] <= edgeCnt[i];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Offers an operand set at a negedge and returns at the negedge of the
  // first cycle after the accept.
  task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] e, input bit keepValid);
    rea = a; ima = b; req = c; imq = e;
    inValid[d] = 1'b1;
    checkOutput($sformatf("in_ready before accept [%0d]", d), 32'(inReady[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keepValid) inValid[d] = 1'b0;
  endtask

  task automatic awaitResult(input int d, input int expLat);
    int n = 1;
    while (outValid[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("latency [%0d]", d), 32'(n), 32'(expLat));
  endtask

  task automatic checkResults(input int d, input logic [7:0] expRe, input logic [7:0] expIm,
                              input bit expEcho);
    checkOutput($sformatf("re_out [%0d]", d), 32'(reOut[d]), 32'(expRe));
    checkOutput($sformatf("im_out [%0d]", d), 32'(imOut[d]), 32'(expIm));
    checkOutput($sformatf("echo_err [%0d]", d), 32'(echoErr[d]), 32'(expEcho));
    checkOutput($sformatf("in_ready during out_valid [%0d]", d), 32'(inReady[d]), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("in_ready after out_valid [%0d]", d), 32'(inReady[d]), 32'd1);
    checkOutput($sformatf("strobe rises [%0d]", d), 32'(lastEdges[d]), 32'd5);
    checkOutput($sformatf("data stability [%0d]", d), 32'(violations[d]), 32'd0);
  endtask

  initial begin
    int pulses;
    nreset = 1'b0;
    inValid = 2'b00;
    faultOn = 1'b0;
    rea = 8'h00; ima = 8'h00; req = 8'h00; imq = 8'h00;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset sw_out [%0d]", d), 32'(swOut[d]), 32'd0);
      checkOutput($sformatf("reset in_ready [%0d]", d), 32'(inReady[d]), 32'd1);
      checkOutput($sformatf("reset out_valid [%0d]", d), 32'(outValid[d]), 32'd0);
      checkOutput($sformatf("reset echo_err [%0d]", d), 32'(echoErr[d]), 32'd0);
      checkOutput($sformatf("reset re_out [%0d]", d), 32'(reOut[d]), 32'd0);
      checkOutput($sformatf("reset im_out [%0d]", d), 32'(imOut[d]), 32'd0);
    end
    nreset = 1'b1;
    @(negedge clk);

    $display("[TB] nominal transaction, HOLD=4");
    applyStimulus(0, 8'h40, 8'h20, 8'h40, 8'h40, 1'b0);
    awaitResult(0, 60);
    checkResults(0, 8'h10, 8'h30, 1'b0);

    $display("[TB] signed operands");
    applyStimulus(0, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0);
    awaitResult(0, 60);
    checkResults(0, 8'h80, 8'h00, 1'b0);

    $display("[TB] echo fault on second operand");
    faultOn = 1'b1;
    applyStimulus(0, 8'h40, 8'h20, 8'h40, 8'h40, 1'b0);
    awaitResult(0, 60);
    checkResults(0, 8'h10, 8'h30, 1'b1);
    faultOn = 1'b0;
    applyStimulus(0, 8'h40, 8'h20, 8'h40, 8'h40, 1'b0);
    checkOutput("echo_err cleared on accept", 32'(echoErr[0]), 32'd0);
    awaitResult(0, 60);
    checkResults(0, 8'h10, 8'h30, 1'b0);

    $display("[TB] reset during third ASSERT");
    applyStimulus(0, 8'h40, 8'h20, 8'h40, 8'h40, 1'b0);
    repeat (29) @(negedge clk);
    checkOutput("strobe high in third ASSERT", 32'(swOut[0][8]), 32'd1);
    nreset = 1'b0;
    #1;
    checkOutput("sw_out async reset", 32'(swOut[0]), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", 32'(inReady[0]), 32'd1);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (outValid[0]) pulses++;
      @(negedge clk);
    end
    checkOutput("no out_valid after reset", 32'(pulses), 32'd0);
    applyStimulus(0, 8'h40, 8'h20, 8'h40, 8'h40, 1'b0);
    awaitResult(0, 60);
    checkResults(0, 8'h10, 8'h30, 1'b0);

    $display("[TB] in_valid held high, HOLD=3");
    applyStimulus(1, 8'h10, 8'h08, 8'h20, 8'h10, 1'b1);
    rea = 8'hC0; ima = 8'h40; req = 8'h40; imq = 8'h20;
    awaitResult(1, 45);
    checkResults(1, 8'h03, 8'h04, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready busy after back-to-back accept", 32'(inReady[1]), 32'd0);
    rea = 8'h01; ima = 8'h01; req = 8'h01; imq = 8'h01;
    awaitResult(1, 45);
    checkResults(1, 8'hD0, 8'h10, 1'b0);
    inValid[1] = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
